// File: rtl/ycbcr_to_rgb_stage_cbcr_if.sv
// ---------------------------------------------------------------------------
// ycbcr_to_rgb_stage_cbcr_if
// Groups the two handshake sides of the Cb/Cr stage:
//   sample side (from the Y stage, no backpressure)
//     valid_i        one Y sample presented this cycle
//     state_i[1:0]   channel tag, 1=R, 2=G, 0=B
//     y_accum_i[7:0] Y sample
//     cb_i[7:0]      Cb, meaningful with the R-tagged sample only
//     cr_i[7:0]      Cr, meaningful with the R-tagged sample only
//   pixel side (valid/ready)
//     pixel_valid_o  packed pixel available
//     pixel_ready_i  consumer takes the pixel when valid & ready
//     pixel_o[23:0]  {R, G, B}
// master: the environment (producer of samples, consumer of pixels)
// slave:  the Cb/Cr stage
// ---------------------------------------------------------------------------
interface ycbcr_to_rgb_stage_cbcr_if;
  logic        valid_i;
  logic [1:0]  state_i;
  logic [7:0]  y_accum_i;
  logic [7:0]  cb_i;
  logic [7:0]  cr_i;
  logic        pixel_valid_o;
  logic        pixel_ready_i;
  logic [23:0] pixel_o;

  modport master (
    output valid_i, state_i, y_accum_i, cb_i, cr_i, pixel_ready_i,
    input  pixel_valid_o, pixel_o
  );

  modport slave (
    input  valid_i, state_i, y_accum_i, cb_i, cr_i, pixel_ready_i,
    output pixel_valid_o, pixel_o
  );
endinterface

// File: rtl/ycbcr_to_rgb_stage_cbcr.sv
// ---------------------------------------------------------------------------
// ycbcr_to_rgb_stage_cbcr
// Takes the Y stage's per-channel sample stream, adds the Cb/Cr matrix term
// for the tagged channel, rounds, clamps to 8 bits and packs R,G,B into one
// 24-bit pixel held in a single-entry valid/ready output register.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   bus         ycbcr_to_rgb_stage_cbcr_if.slave (sample in, pixel out)
//   overflow_o  sticky: a completed pixel was dropped, output register full
//   seq_err_o   sticky: a channel tag arrived out of order
//
// Expected-tag sequencer (exp_tag)
//   state  | meaning
//   TAG_R  | idle / waiting for the R sample that starts a triple
//   TAG_G  | R accepted, waiting for G
//   TAG_B  | R and G accepted, waiting for B
// ---------------------------------------------------------------------------
module ycbcr_to_rgb_stage_cbcr #(
  parameter int FRAC  = 8,
  parameter int C_RCR = 359,
  parameter int C_GCB = 88,
  parameter int C_GCR = 183,
  parameter int C_BCB = 454
) (
  input  logic                          clk,
  input  logic                          rst,
  ycbcr_to_rgb_stage_cbcr_if.slave      bus,
  output logic                          overflow_o,
  output logic                          seq_err_o
);

  localparam logic [1:0] TAG_R = 2'd1;
  localparam logic [1:0] TAG_G = 2'd2;
  localparam logic [1:0] TAG_B = 2'd0;

  // 20 bits covers the worst case (255<<8) + 454*128 + rounding with sign.
  localparam int AW = 20;

  localparam logic signed [AW-1:0] K_RCR = AW'(C_RCR);
  localparam logic signed [AW-1:0] K_GCB = AW'(C_GCB);
  localparam logic signed [AW-1:0] K_GCR = AW'(C_GCR);
  localparam logic signed [AW-1:0] K_BCB = AW'(C_BCB);
  localparam logic signed [AW-1:0] RND   = AW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] MAXV  = AW'(255);

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  logic [1:0] exp_tag;
  logic       tag_match;
  logic       tag_err;
  logic       take;
  logic       flush;
  logic       is_r;

  assign is_r      = (bus.state_i == TAG_R);
  assign tag_match = bus.valid_i && (bus.state_i == exp_tag);
  assign tag_err   = bus.valid_i && (bus.state_i != exp_tag);
  // An out-of-order R still starts a fresh triple.
  assign take      = tag_match || (tag_err && is_r);
  // Only a triple that has begun has anything to throw away. When exp_tag is
  // TAG_R the previous triple's B may still be in flight and must survive.
  assign flush     = tag_err && (exp_tag != TAG_R);

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_tag <= TAG_R;
    end else if (bus.valid_i) begin
      if (take) begin
        case (bus.state_i)
          TAG_R:   exp_tag <= TAG_G;
          TAG_G:   exp_tag <= TAG_B;
          default: exp_tag <= TAG_R;
        endcase
      end else begin
        exp_tag <= TAG_R;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_o <= 1'b0;
    end else if (tag_err) begin
      seq_err_o <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Chroma offsets: captured with the R sample, reused for G and B. The R
  // sample itself uses the live inputs since the register is not loaded yet.
  // -------------------------------------------------------------------------
  logic signed [8:0] dcb_in;
  logic signed [8:0] dcr_in;
  logic signed [8:0] dcb_q;
  logic signed [8:0] dcr_q;
  logic signed [8:0] dcb_s;
  logic signed [8:0] dcr_s;

  assign dcb_in = $signed({1'b0, bus.cb_i}) - 9'sd128;
  assign dcr_in = $signed({1'b0, bus.cr_i}) - 9'sd128;
  assign dcb_s  = is_r ? dcb_in : dcb_q;
  assign dcr_s  = is_r ? dcr_in : dcr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dcb_q <= '0;
      dcr_q <= '0;
    end else if (take && is_r) begin
      dcb_q <= dcb_in;
      dcr_q <= dcr_in;
    end
  end

  // -------------------------------------------------------------------------
  // Matrix term for the tagged channel
  // -------------------------------------------------------------------------
  logic signed [AW-1:0] dcb_w;
  logic signed [AW-1:0] dcr_w;
  logic signed [AW-1:0] term_r;
  logic signed [AW-1:0] term_g;
  logic signed [AW-1:0] term_b;
  logic signed [AW-1:0] term_s;

  assign dcb_w  = {{(AW-9){dcb_s[8]}}, dcb_s};
  assign dcr_w  = {{(AW-9){dcr_s[8]}}, dcr_s};
  assign term_r = K_RCR * dcr_w;
  assign term_g = -(K_GCB * dcb_w) - (K_GCR * dcr_w);
  assign term_b = K_BCB * dcb_w;

  always_comb begin
    term_s = '0;
    case (bus.state_i)
      TAG_R:   term_s = term_r;
      TAG_G:   term_s = term_g;
      TAG_B:   term_s = term_b;
      default: term_s = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // P1: registered term, Y and tag
  // -------------------------------------------------------------------------
  logic                 p1_valid;
  logic [1:0]           p1_tag;
  logic [7:0]           p1_y;
  logic signed [AW-1:0] p1_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_tag   <= TAG_R;
      p1_y     <= '0;
      p1_term  <= '0;
    end else begin
      p1_valid <= take;
      if (take) begin
        p1_tag  <= bus.state_i;
        p1_y    <= bus.y_accum_i;
        p1_term <= term_s;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sum, round, arithmetic shift, clamp
  // -------------------------------------------------------------------------
  logic signed [AW-1:0] y_w;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] res;
  logic [7:0]           chan;

  assign y_w = {{(AW-8){1'b0}}, p1_y};
  assign acc = (y_w <<< FRAC) + p1_term + RND;
  assign res = acc >>> FRAC;

  always_comb begin
    chan = 8'd0;
    if (res < 0) begin
      chan = 8'd0;
    end else if (res > MAXV) begin
      chan = 8'hff;
    end else begin
      chan = res[7:0];
    end
  end

  // -------------------------------------------------------------------------
  // P2: channel slots. R and G park here until the B of the same triple
  // arrives; B goes straight into the output register.
  // -------------------------------------------------------------------------
  logic [7:0] r_q;
  logic [7:0] g_q;
  logic       r_ok;
  logic       g_ok;
  logic       complete;

  assign complete = p1_valid && !flush && (p1_tag == TAG_B) && r_ok && g_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= '0;
      g_q  <= '0;
      r_ok <= 1'b0;
      g_ok <= 1'b0;
    end else if (flush) begin
      // Whatever sits in P1 belongs to the abandoned triple; do not park it.
      r_ok <= 1'b0;
      g_ok <= 1'b0;
    end else if (p1_valid) begin
      case (p1_tag)
        TAG_R: begin
          r_q  <= chan;
          r_ok <= 1'b1;
        end
        TAG_G: begin
          g_q  <= chan;
          g_ok <= 1'b1;
        end
        default: begin
          r_ok <= 1'b0;
          g_ok <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output register (single entry, valid/ready)
  // -------------------------------------------------------------------------
  logic        pix_valid;
  logic [23:0] pix_q;
  logic        drain;
  logic        load_ok;

  assign drain   = pix_valid && bus.pixel_ready_i;
  assign load_ok = !pix_valid || drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (complete) begin
        if (load_ok) begin
          pix_valid <= 1'b1;
          pix_q     <= {r_q, g_q, chan};
        end else begin
          overflow_o <= 1'b1;
        end
      end else if (drain) begin
        pix_valid <= 1'b0;
      end
    end
  end

  assign bus.pixel_valid_o = pix_valid;
  assign bus.pixel_o       = pix_q;

endmodule

// File: tb/tb_ycbcr_to_rgb_stage_cbcr.sv
// ---------------------------------------------------------------------------
// tb_ycbcr_to_rgb_stage_cbcr
// Directed stimulus with literal expectations, plus a triple-level reference
// model compared against the DUT outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_ycbcr_to_rgb_stage_cbcr;
  logic clk = 1'b0;
  logic rst;
  logic overflow;
  logic seq_err;

  int n_total = 0;
  int n_bad   = 0;

  ycbcr_to_rgb_stage_cbcr_if bus ();

  ycbcr_to_rgb_stage_cbcr dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .overflow_o (overflow),
    .seq_err_o  (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] chan_m(input int y, input int term);
    int v;
    v = y * 256 + term + 128;
    if (v < 0) return 8'd0;
    v = v / 256;
    if (v > 255) return 8'hff;
    return 8'(v);
  endfunction

  function automatic logic [23:0] pix_m(input int yr, input int yg, input int yb,
                                        input int cb, input int cr);
    int dcb;
    int dcr;
    dcb = cb - 128;
    dcr = cr - 128;
    return {chan_m(yr, 359 * dcr), chan_m(yg, -88 * dcb - 183 * dcr), chan_m(yb, 454 * dcb)};
  endfunction

  logic        model_live = 1'b0;
  logic        m_valid    = 1'b0;
  logic [23:0] m_pix      = '0;
  logic        m_ovf      = 1'b0;
  logic        m_seq      = 1'b0;
  int          m_exp      = 1;
  logic        pend       = 1'b0;
  logic [23:0] pend_pix   = '0;
  int          t_yr, t_yg, t_cb, t_cr;

  always @(posedge clk) begin
    logic drained;
    int   st;
    if (rst) begin
      model_live = 1'b1;
      m_valid = 1'b0; m_pix = '0; m_ovf = 1'b0; m_seq = 1'b0;
      m_exp = 1; pend = 1'b0;
    end else if (model_live) begin
      drained = m_valid && bus.pixel_ready_i;
      if (pend) begin
        if (!m_valid || drained) begin
          m_valid = 1'b1;
          m_pix   = pend_pix;
        end else begin
          m_ovf = 1'b1;
        end
        pend = 1'b0;
      end else if (drained) begin
        m_valid = 1'b0;
      end
      if (bus.valid_i) begin
        st = int'(bus.state_i);
        if (st != m_exp) m_seq = 1'b1;
        if (st == 1) begin
          t_yr = bus.y_accum_i; t_cb = bus.cb_i; t_cr = bus.cr_i;
          m_exp = 2;
        end else if (st == m_exp && st == 2) begin
          t_yg = bus.y_accum_i;
          m_exp = 0;
        end else if (st == m_exp && st == 0) begin
          pend     = 1'b1;
          pend_pix = pix_m(t_yr, t_yg, bus.y_accum_i, t_cb, t_cr);
          m_exp    = 1;
        end else begin
          m_exp = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_pixel_valid", bus.pixel_valid_o, m_valid);
      if (m_valid) chk("model_pixel", bus.pixel_o, m_pix);
      chk("model_overflow", overflow, m_ovf);
      chk("model_seq_err", seq_err, m_seq);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] tag, input logic [7:0] y,
                      input logic [7:0] cb, input logic [7:0] cr);
    bus.valid_i   = 1'b1;
    bus.state_i   = tag;
    bus.y_accum_i = y;
    bus.cb_i      = cb;
    bus.cr_i      = cr;
    tick();
    bus.valid_i   = 1'b0;
  endtask

  task automatic triple(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    send(2'd1, y, cb, cr);
    send(2'd2, y, 8'd0, 8'd0);
    send(2'd0, y, 8'd0, 8'd0);
  endtask

  // Called right after the B sample: pixel must be absent one cycle, present the next.
  task automatic expect_next(input string name, input logic [23:0] exp);
    @(negedge clk);
    chk({name, "_early"}, bus.pixel_valid_o, 1'b0);
    tick();
    @(negedge clk);
    chk({name, "_valid"}, bus.pixel_valid_o, 1'b1);
    chk({name, "_pixel"}, bus.pixel_o, exp);
    tick();
  endtask

  task automatic count_pixels(input int ncyc, output int cnt, output logic [23:0] last);
    cnt  = 0;
    last = '0;
    repeat (ncyc) begin
      @(negedge clk);
      if (bus.pixel_valid_o) begin
        cnt++;
        last = bus.pixel_o;
      end
    end
    tick();
  endtask

  // mixed table: tag, y, cb, cr, idle cycles after, ready while sending
  int tb_tag[17] = '{1, 2, 0, 1, 2, 0, 1, 1, 2, 0, 3, 1, 2, 0, 1, 2, 0};
  int tb_y  [17] = '{30, 40, 50, 90, 90, 90, 60, 70, 80, 90, 5, 255, 255, 255, 0, 0, 0};
  int tb_cb [17] = '{200, 0, 0, 20, 7, 7, 128, 100, 0, 0, 9, 255, 1, 1, 0, 3, 3};
  int tb_cr [17] = '{60, 0, 0, 240, 7, 7, 128, 150, 0, 0, 9, 0, 1, 1, 255, 3, 3};
  int tb_gap[17] = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  int tb_rdy[17] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          cnt;
    logic [23:0] last;

    bus.valid_i = 1'b0; bus.state_i = 2'd0; bus.y_accum_i = '0;
    bus.cb_i = '0; bus.cr_i = '0; bus.pixel_ready_i = 1'b1;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("reset_valid", bus.pixel_valid_o, 1'b0);
    chk("reset_pixel", bus.pixel_o, 24'h0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_seq_err", seq_err, 1'b0);
    chk("model_pin_fffa4ff", pix_m(255, 255, 255, 128, 255), 24'hFFA4FF);
    rst = 1'b0;
    tick();

    // 1: neutral grey, latency
    triple(8'd128, 8'd128, 8'd128);
    expect_next("t1", 24'h808080);

    // 2: R clamps high, G=164, B=255; G/B carry junk chroma that must be ignored
    triple(8'd255, 8'd128, 8'd255);
    expect_next("t2", 24'hFFA4FF);

    // 3: R,B clamp low, G=136
    triple(8'd0, 8'd0, 8'd0);
    expect_next("t3", 24'h008800);

    // 4: backpressure, second pixel dropped
    bus.pixel_ready_i = 1'b0;
    triple(8'd100, 8'd128, 8'd128);
    triple(8'd50, 8'd128, 8'd128);
    tick(); tick(); tick();
    @(negedge clk);
    chk("t4_held_valid", bus.pixel_valid_o, 1'b1);
    chk("t4_held_pixel", bus.pixel_o, 24'h646464);
    chk("t4_overflow", overflow, 1'b1);
    tick();
    bus.pixel_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_first_out", bus.pixel_o, 24'h646464);
    tick();
    @(negedge clk);
    chk("t4_drained", bus.pixel_valid_o, 1'b0);
    tick();

    // 5: tags 1,0 then a clean triple
    send(2'd1, 8'd10, 8'd128, 8'd128);
    send(2'd0, 8'd10, 8'd128, 8'd128);
    triple(8'd200, 8'd128, 8'd128);
    count_pixels(6, cnt, last);
    chk("t5_seq_err", seq_err, 1'b1);
    chk("t5_count", cnt, 1);
    chk("t5_pixel", last, 24'hC8C8C8);

    // 6: reset mid-triple
    send(2'd1, 8'd1, 8'd128, 8'd128);
    send(2'd2, 8'd1, 8'd128, 8'd128);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_overflow_cleared", overflow, 1'b0);
    chk("t6_seq_err_cleared", seq_err, 1'b0);
    chk("t6_valid_cleared", bus.pixel_valid_o, 1'b0);
    tick();
    triple(8'd77, 8'd128, 8'd128);
    count_pixels(6, cnt, last);
    chk("t6_count", cnt, 1);
    chk("t6_pixel", last, 24'h4D4D4D);
    chk("t6_flags", {30'd0, overflow, seq_err}, 32'd0);

    // 7: mixed gaps, restarts, bad tag, ready toggling (model-checked)
    for (int i = 0; i < 17; i++) begin
      bus.pixel_ready_i = tb_rdy[i][0];
      send(2'(tb_tag[i]), 8'(tb_y[i]), 8'(tb_cb[i]), 8'(tb_cr[i]));
      repeat (tb_gap[i]) tick();
    end
    bus.pixel_ready_i = 1'b1;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
